// File: rtl/loader_pkg.sv
// Shared definitions for the boot-image loader: FSM encoding and default image geometry.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_REG,
        LOAD_MEM,
        RELEASE,
        DONE,
        ERROR
    } state_t;

    localparam int unsigned DEF_NUM_REGS  = 32;
    localparam logic [31:0] DEF_MEM_BASE  = 32'h0000_4000;
    localparam int unsigned DEF_MEM_WORDS = 4;

endpackage

// File: rtl/state_loader.sv
// Streams a machine image into the register file and then data memory, holding the
// CPU in reset until a correctly framed image has been written.
module state_loader
    import loader_pkg::*;
#(
    parameter int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter logic [31:0] MEM_BASE  = DEF_MEM_BASE,
    parameter int unsigned MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_wdata,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        err
);

    localparam int unsigned   CW       = $clog2(NUM_REGS + MEM_WORDS) + 1;
    localparam logic [CW-1:0] LAST_REG = CW'(NUM_REGS - 1);
    localparam logic [CW-1:0] LAST_MEM = CW'(MEM_WORDS - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          rf_we_q;
    logic [4:0]    rf_addr_q;
    logic [31:0]   rf_wdata_q;
    logic          mem_we_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic          cpu_reset_q;
    logic          done_q;
    logic          err_q;

    logic xfer;
    logic mem_final;

    always_comb begin
        in_ready  = (state_q == LOAD_REG) || (state_q == LOAD_MEM);
        xfer      = in_valid && in_ready;
        mem_final = (cnt_q == LAST_MEM);
    end

    // The final image word always falls in the memory phase, so in_last is never legal during LOAD_REG.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wdata_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            rf_we_q  <= 1'b0;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state_q     <= LOAD_REG;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        cpu_reset_q <= 1'b1;
                    end
                end
                LOAD_REG: begin
                    if (xfer) begin
                        if (in_last) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            rf_we_q    <= 1'b1;
                            rf_addr_q  <= 5'(cnt_q);
                            rf_wdata_q <= in_data;
                            if (cnt_q == LAST_REG) begin
                                state_q <= LOAD_MEM;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                end
                LOAD_MEM: begin
                    if (xfer) begin
                        if (in_last != mem_final) begin
                            state_q <= ERROR;
                            err_q   <= 1'b1;
                        end else begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= MEM_BASE + 32'(cnt_q);
                            mem_wdata_q <= in_data;
                            if (mem_final) begin
                                state_q <= RELEASE;
                            end else begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end
                    end
                end
                RELEASE: begin
                    state_q     <= DONE;
                    cpu_reset_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wdata  = rf_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_state_loader.sv
// Table-driven bench for state_loader plus a small second instance exercising address wrap.
module tb_state_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, in_valid, in_last;
    logic [31:0] in_data;
    logic        in_ready, rf_we, mem_we, cpu_reset, done, err;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata, mem_addr, mem_wdata;

    logic        w_rst, w_start, w_valid, w_last;
    logic [31:0] w_data;
    logic        w_ready, w_rf_we, w_mem_we, w_cpu, w_done, w_err;
    logic [4:0]  w_rf_addr;
    logic [31:0] w_rf_wdata, w_mem_addr, w_mem_wdata;

    state_loader #(.NUM_REGS(32), .MEM_BASE(32'h0000_4000), .MEM_WORDS(4)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .rf_we(rf_we), .rf_addr(rf_addr),
        .rf_wdata(rf_wdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    state_loader #(.NUM_REGS(2), .MEM_BASE(32'hFFFF_FFFE), .MEM_WORDS(4)) u_wrap (
        .clk(clk), .reset(w_rst), .start(w_start), .in_valid(w_valid), .in_data(w_data),
        .in_last(w_last), .in_ready(w_ready), .rf_we(w_rf_we), .rf_addr(w_rf_addr),
        .rf_wdata(w_rf_wdata), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .cpu_reset(w_cpu), .done(w_done), .err(w_err)
    );

    typedef struct {
        logic        rst_n, start, valid, last;
        logic [31:0] data;
        logic        e_ready, e_rf_we, e_mem_we, e_cpu, e_done, e_err;
        logic [4:0]  e_rf_addr;
        logic [31:0] e_rf_wdata, e_mem_addr, e_mem_wdata;
        logic        full;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t base();
        vec_t v;
        v = '{default: '0};
        v.rst_n = 1'b1;
        v.e_cpu = 1'b1;
        return v;
    endfunction

    function automatic void add_idle(logic st, logic rdy, logic cpu, logic dn, logic er);
        vec_t v;
        v = base();
        v.start = st; v.e_ready = rdy; v.e_cpu = cpu; v.e_done = dn; v.e_err = er;
        tbl.push_back(v);
    endfunction

    // Accepted image word i carries data i+1: r0..r31 first, then 0x4000.. in memory.
    function automatic void add_word(int i, logic last, logic st);
        vec_t v;
        v = base();
        v.start = st; v.valid = 1'b1; v.data = 32'(i + 1); v.last = last;
        v.e_ready = (i != 35);
        if (i < 32) begin
            v.e_rf_we = 1'b1; v.e_rf_addr = 5'(i); v.e_rf_wdata = 32'(i + 1);
        end else begin
            v.e_mem_we = 1'b1; v.e_mem_addr = 32'h0000_4000 + 32'(i - 32); v.e_mem_wdata = 32'(i + 1);
        end
        tbl.push_back(v);
    endfunction

    function automatic void add_bad(int i, logic last);
        vec_t v;
        v = base();
        v.valid = 1'b1; v.data = 32'(i + 1); v.last = last; v.e_err = 1'b1;
        tbl.push_back(v);
    endfunction

    function automatic void add_stall();
        vec_t v;
        v = base();
        v.data = 32'hDEAD_BEEF; v.last = 1'b1; v.e_ready = 1'b1;
        tbl.push_back(v);
    endfunction

    function automatic void add_reset(logic valid);
        vec_t v;
        v = base();
        v.rst_n = 1'b0; v.valid = valid; v.data = 32'h1234_5678; v.full = 1'b1;
        tbl.push_back(v);
    endfunction

    function automatic void add_after_reset();
        vec_t v;
        v = base();
        v.valid = 1'b1; v.data = 32'hCAFE_0000; v.full = 1'b1;
        tbl.push_back(v);
    endfunction

    function automatic void add_image(int stall_after, int start_on, logic rel_start);
        for (int i = 0; i < 36; i++) begin
            add_word(i, i == 35, i == start_on);
            if (i == stall_after) for (int s = 0; s < 3; s++) add_stall();
        end
        add_idle(rel_start, 1'b0, 1'b0, 1'b1, 1'b0);
        add_idle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic apply(input vec_t v, input int k);
        logic ok;
        @(negedge clk);
        reset = v.rst_n; start = v.start; in_valid = v.valid; in_last = v.last; in_data = v.data;
        @(posedge clk);
        #1;
        ok = ({in_ready, rf_we, mem_we, cpu_reset, done, err} ===
              {v.e_ready, v.e_rf_we, v.e_mem_we, v.e_cpu, v.e_done, v.e_err});
        if (v.full || v.e_rf_we)
            ok = ok && (rf_addr === v.e_rf_addr) && (rf_wdata === v.e_rf_wdata);
        if (v.full || v.e_mem_we)
            ok = ok && (mem_addr === v.e_mem_addr) && (mem_wdata === v.e_mem_wdata);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL vec %0d: got rdy/rfwe/memwe/cpurst/done/err=%b rf[%0d]=%h mem[%h]=%h, want %b rf[%0d]=%h mem[%h]=%h",
                     k, {in_ready, rf_we, mem_we, cpu_reset, done, err}, rf_addr, rf_wdata, mem_addr, mem_wdata,
                     {v.e_ready, v.e_rf_we, v.e_mem_we, v.e_cpu, v.e_done, v.e_err},
                     v.e_rf_addr, v.e_rf_wdata, v.e_mem_addr, v.e_mem_wdata);
        end
    endtask

    task automatic wstep(input logic r, input logic s, input logic v, input logic l, input logic [31:0] d);
        @(negedge clk);
        w_rst = r; w_start = s; w_valid = v; w_last = l; w_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    logic [31:0] wexp [4];

    initial begin
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        w_rst = 1'b0; w_start = 1'b0; w_valid = 1'b0; w_last = 1'b0; w_data = '0;
        wexp = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        // Reset, full image with a stray start mid-load and another during RELEASE.
        add_reset(1'b0);
        add_idle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        add_idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_image(-1, 3, 1'b1);
        // Reload from DONE with a 3-cycle stall after word 10 and a stray start in LOAD_MEM.
        add_idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_image(10, 33, 1'b0);
        // Early last on word 20, then start clears err.
        add_idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) add_word(i, 1'b0, 1'b0);
        add_bad(20, 1'b1);
        add_bad(21, 1'b0);
        add_bad(22, 1'b0);
        add_idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        // Missing last on word 35.
        for (int i = 0; i < 35; i++) add_word(i, 1'b0, 1'b0);
        add_bad(35, 1'b0);
        add_idle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        // Reset mid-load after word 5, then a clean load from IDLE.
        add_idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) add_word(i, 1'b0, 1'b0);
        add_reset(1'b1);
        add_after_reset();
        add_after_reset();
        add_idle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add_image(-1, -1, 1'b0);

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k], k);

        // Memory address wrap past 2^32 on a small image.
        wstep(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_reset", {w_ready, w_rf_we, w_mem_we, w_cpu, w_done, w_err}, 6'b000100);
        wstep(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("wrap_start", {w_ready, w_rf_we, w_mem_we, w_cpu, w_done, w_err}, 6'b100100);
        for (int i = 0; i < 6; i++) begin
            wstep(1'b1, 1'b0, 1'b1, i == 5, 32'(100 + i));
            if (i < 2)
                chk("wrap_rf", {w_rf_we, w_mem_we, w_rf_addr, w_rf_wdata}, {1'b1, 1'b0, 5'(i), 32'(100 + i)});
            else
                chk("wrap_mem", {w_rf_we, w_mem_we, w_mem_addr, w_mem_wdata}, {1'b0, 1'b1, wexp[i-2], 32'(100 + i)});
        end
        wstep(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("wrap_done", {w_cpu, w_done, w_ready, w_err}, 4'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
